// File: rtl/neander_core_param_if.sv
// Memory bus between the Neander core and its unified memory.
// The core drives address, write data and write strobe; the memory
// returns read data combinationally for the address currently presented.
interface neander_core_param_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/neander_core_param.sv
// Parametrised Neander accumulator core.
// Multi-cycle FSM: FETCH -> DECODE -> (OPERAND -> (EXEC)) -> FETCH, plus a
// terminal HALT state. Memory is external with combinational read and
// write on the rising edge while mem_we is high.
module neander_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    neander_core_param_if.master bus,
    output logic [ADDR_W-1:0]    pc,
    output logic [DATA_W-1:0]    ac,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 halted,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_OPERAND = 3'd2,
        S_EXEC    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] rem;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand_addr;
    logic              jump_op;
    logic              jump_taken;

    assign opcode       = ir[DATA_W-1 -: 4];
    assign operand_addr = bus.mem_rdata[ADDR_W-1:0];
    assign jump_op      = (opcode == OP_JMP) || (opcode == OP_JN) || (opcode == OP_JZ);
    assign jump_taken   = (opcode == OP_JMP)
                       || ((opcode == OP_JN) && flag_n)
                       || ((opcode == OP_JZ) && flag_z);

    assign flag_n = ac[DATA_W-1];
    assign flag_z = (ac == '0);
    assign halted = (state_r == S_HALT);
    assign state  = state_r;

    // Only EXEC addresses the operand; every other state points at pc.
    assign bus.mem_addr  = (state_r == S_EXEC) ? rem : pc;
    assign bus.mem_wdata = ac;
    // Gating with reset keeps a STA caught by reset from landing in memory
    // on the very edge that discards it.
    assign bus.mem_we    = enable && !reset && (state_r == S_EXEC) && (opcode == OP_STA);

    // Instruction sequencing: fetch, decode, operand fetch and execute.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // sees the pre-edge values of the others, exactly like the hardware.
        if (reset) begin
            state_r <= S_FETCH;
            pc      <= '0;
            ac      <= '0;
            ir      <= '0;
            rem     <= '0;
        end else if (enable) begin
            case (state_r)
                S_FETCH: begin
                    ir      <= bus.mem_rdata;
                    pc      <= pc + PC_STEP;
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOT: begin
                            ac      <= ~ac;
                            state_r <= S_FETCH;
                        end
                        OP_HLT: state_r <= S_HALT;
                        OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND,
                        OP_JMP, OP_JN, OP_JZ: state_r <= S_OPERAND;
                        default: state_r <= S_FETCH; // NOP and unassigned opcodes
                    endcase
                end
                S_OPERAND: begin
                    if (jump_op) begin
                        pc      <= jump_taken ? operand_addr : pc + PC_STEP;
                        state_r <= S_FETCH;
                    end else begin
                        rem     <= operand_addr;
                        pc      <= pc + PC_STEP;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LDA:  ac <= bus.mem_rdata;
                        OP_ADD:  ac <= ac + bus.mem_rdata;
                        OP_OR:   ac <= ac | bus.mem_rdata;
                        OP_AND:  ac <= ac & bus.mem_rdata;
                        default: ac <= ac; // STA writes through mem_we
                    endcase
                    state_r <= S_FETCH;
                end
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/neander_core_param.md
Name: neander_core_param

Overview:
- Parametrised successor to the 8-bit Neander accumulator machine. Implements the full Neander instruction set: NOP, STA, LDA, ADD, OR, AND, NOT, JMP, JN, JZ and HLT.
- Maintains N/Z flags, a halt indication and a stall input.
- Connects to an external unified memory with combinational read and clocked write; that memory sits beside the core at the top level.

Parameters:
- DATA_W, 8: accumulator and memory word width; must be >= 4 and >= ADDR_W.
- ADDR_W, 8: PC, REM and memory address width.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: when 0, all core registers hold and mem_we=0.
- mem_addr, output, ADDR_W: memory address (combinational from state, pc, rem).
- mem_rdata, input, DATA_W: memory read data, valid in the same cycle as mem_addr.
- mem_wdata, output, DATA_W: write data; always equals ac.
- mem_we, output, 1: write strobe; memory writes on the rising clock edge while high.
- pc, output, ADDR_W: program counter.
- ac, output, DATA_W: accumulator.
- flag_n, output, 1: ac[DATA_W-1].
- flag_z, output, 1: (ac == 0).
- halted, output, 1: high while in HALT.
- state, output, 3: current FSM state encoding, for display/debug.

Behaviour:
- Reset:
  - Synchronous, active-high; on the reset edge it has priority over enable and over any operation in progress.
  - Reset values: pc=0, ac=0, ir=0, rem=0, state=FETCH, halted=0, mem_we=0.
  - flag_z=1 and flag_n=0 follow from ac=0.
- Instruction format:
  - opcode = mem word bits [DATA_W-1:DATA_W-4].
  - Two-word instructions (STA, LDA, ADD, OR, AND, JMP, JN, JZ) take the operand address from the next word, bits [ADDR_W-1:0].
  - Opcode map: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 8 JMP, 9 JN, A JZ, F HLT.
  - Opcodes 7, B, C, D and E execute as NOP.
- State encodings: FETCH=0, DECODE=1, OPERAND=2, EXEC=3, HALT=4.
- FETCH:
  - mem_addr=pc; ir<=mem_rdata; pc<=pc+1; next DECODE.
- DECODE:
  - mem_addr=pc.
  - NOP or unknown opcode: next FETCH.
  - NOT: ac<=~ac; next FETCH.
  - HLT: next HALT; pc is not advanced further.
  - Any other opcode: next OPERAND.
- OPERAND:
  - mem_addr=pc.
  - JMP, or JN with flag_n=1, or JZ with flag_z=1: pc<=mem_rdata[ADDR_W-1:0].
  - Untaken JN/JZ: pc<=pc+1.
  - Jumps then go to FETCH.
  - Memory ops: rem<=mem_rdata[ADDR_W-1:0]; pc<=pc+1; next EXEC.
- EXEC:
  - mem_addr=rem.
  - STA: mem_we=1 (mem_wdata=ac).
  - LDA: ac<=mem_rdata.
  - ADD: ac<=ac+mem_rdata, modulo 2^DATA_W, carry discarded.
  - OR: ac<=ac|mem_rdata.
  - AND: ac<=ac&mem_rdata.
  - Next FETCH.
- HALT:
  - mem_addr=pc; all registers hold; halted=1.
  - Left only by reset.
- Latency per instruction:
  - NOP, NOT, unknown opcodes: 2 cycles.
  - JMP, JN, JZ: 3 cycles.
  - STA, LDA, ADD, OR, AND: 4 cycles.
  - HLT: 2 cycles to reach HALT.
- Flag timing: flags are sampled in OPERAND and reflect ac as updated by all previous instructions.
- mem_we:
  - Asserted only in EXEC for STA with enable=1.
  - Combinational from registered state, so it is glitch-free relative to the clock edge.
- enable=0:
  - Registers and state hold; mem_we forced to 0; mem_addr keeps its current value.
  - Resumes exactly where it stopped.
- Wrap-around:
  - pc wraps from 2^ADDR_W-1 to 0.
  - An operand fetched at address 2^ADDR_W-1 is followed by fetch at 0.
- Reset mid-instruction (any state, including a STA in EXEC): mem_we is 0 in the cycle after reset and the partial instruction is discarded.

Test Plan:
- Load/add/store, DATA_W=8:
  - Program: LDA 0x80, ADD 0x81, STA 0x82, HLT; mem[0x80]=0x05, mem[0x81]=0x07.
  - Required: mem[0x82]=0x0C, ac=0x0C, halted=1 after 4+4+4+2=14 cycles, pc=7.
- Flags and conditional jumps:
  - ac=0x80 from LDA, then JN 0x10 -> pc=0x10.
  - LDA of 0x00, then JZ 0x20 -> pc=0x20.
  - LDA of 0x01, then JZ 0x20 -> not taken; pc advances by 2 from the JZ address.
- NOT, OR, AND, overflow:
  - LDA 0xF0; NOT -> ac=0x0F.
  - OR with 0x30 -> ac=0x3F.
  - AND with 0x0C -> ac=0x0C.
  - ADD 0xFF+0x02 -> ac=0x01, carry dropped.
- Stall and reset:
  - Drop enable for 3 cycles during STA EXEC -> no write occurs while stalled; write happens on the first enabled edge.
  - Assert reset in EXEC of a STA -> no write; pc=0, ac=0, state=0 on the next cycle.
- Parametrisation:
  - DATA_W=12, ADDR_W=10: JMP 0x3FF at 0x3FE is taken.
  - NOP at 0x3FF -> pc wraps to 0x000.
  - ADD 0xFFF+1 -> ac=0x000, flag_z=1.
- Unknown opcode and halt:
  - Opcode 0xB0 -> 2-cycle NOP with no register change except pc+1.
  - HLT -> halted stays 1 and pc is frozen for 20 cycles.
